// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter between N_REQ byte sources. A round-robin
// arbiter picks a pending byte while the transmitter is idle, the byte is
// registered onto o_tx_data, a one-cycle start pulse is issued, and the
// transmitter's busy line is tracked until the frame completes. If busy never
// rises after a start, a sticky timeout error is flagged and the byte dropped.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no byte owned; arbitrate and accept when transmitter idle
// S_LAUNCH   | byte captured; o_tx_start high for this single cycle
// S_WAIT_BSY | waiting for i_tx_busy to rise, bounded by BUSY_TIMEOUT
// S_WAIT_DNE | frame in flight; wait for i_tx_busy to fall, then count it
//
// BYTE_COUNT_INIT is the value o_byte_count takes in reset. It is 0 in normal
// use; a nonzero value lets the 16-bit wrap be exercised without 65536 frames.

module uart_tx_scheduler #(
    parameter int          N_REQ           = 2,
    parameter int          BUSY_TIMEOUT    = 8,
    parameter logic [15:0] BYTE_COUNT_INIT = 16'h0000
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [8*N_REQ-1:0]       i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_busy,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_active,
    output logic                     o_err_timeout,
    input  logic                     i_err_clear,
    output logic [15:0]              o_byte_count
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LAUNCH   = 2'd1;
    localparam logic [1:0] S_WAIT_BSY = 2'd2;
    localparam logic [1:0] S_WAIT_DNE = 2'd3;

    localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

    logic [1:0]    state_q;
    logic [GW-1:0] ptr_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    tx_data_q;
    logic [GW-1:0] grant_q;
    logic          start_q;
    logic          err_q;
    logic [15:0]   count_q;

    logic [GW:0]   cand;
    logic [GW-1:0] cand_idx;
    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [7:0]    win_data;
    logic [GW-1:0] next_ptr;
    logic          accept;
    logic          timeout_hit;

    // Round-robin search: first valid requester starting at ptr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(N_REQ)) begin
                cand = cand - (GW+1)'(N_REQ);
            end
            cand_idx = cand[GW-1:0];
            if (!win_found && i_req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Select the winning requester's byte out of the packed data bus.
    always_comb begin
        win_data = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == GW'(k)) begin
                win_data = i_req_data[8*k +: 8];
            end
        end
    end

    // Pointer moves one past the winner, wrapping after the last requester.
    always_comb begin
        if (win_idx == GW'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + GW'(1);
        end
    end

    assign accept      = (state_q == S_IDLE) && !i_tx_busy && win_found;
    assign timeout_hit = (state_q == S_WAIT_BSY) && !i_tx_busy && (tmr_q == TMR_LAST);

    // One-hot accept strobe; forced low while reset is held so no byte is
    // offered a handshake during reset.
    always_comb begin
        o_req_ready = '0;
        if (accept && i_reset_n) begin
            o_req_ready[win_idx] = 1'b1;
        end
    end

    // Main sequencing FSM with the busy-rise timer.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tmr_q   <= '0;
                    state_q <= S_WAIT_BSY;
                end
                S_WAIT_BSY: begin
                    if (i_tx_busy) begin
                        state_q <= S_WAIT_DNE;
                    end else if (tmr_q == TMR_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_WAIT_DNE: begin
                    if (!i_tx_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Capture byte, owner and next pointer on accept; hold them otherwise.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr_q     <= '0;
            tx_data_q <= 8'h00;
            grant_q   <= '0;
        end else if (accept) begin
            ptr_q     <= next_ptr;
            tx_data_q <= win_data;
            grant_q   <= win_idx;
        end
    end

    // Start pulse is registered so it lands exactly on the LAUNCH cycle.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= accept;
        end
    end

    // Sticky timeout error; a simultaneous set beats the clear.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (i_err_clear) begin
            err_q <= 1'b0;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= BYTE_COUNT_INIT;
        end else if ((state_q == S_WAIT_DNE) && !i_tx_busy) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_start    = start_q;
    assign o_grant_id    = grant_q;
    assign o_active      = (state_q != S_IDLE);
    assign o_err_timeout = err_q;
    assign o_byte_count  = count_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small transmitter busy model and
// a scoreboard of expected (grant, byte) pairs checked at each start pulse.
// A second instance with a preloaded byte counter runs in lockstep to cover
// the 0xFFFF -> 0x0000 wrap.

module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic [1:0]  i_req_valid = 2'b00;
    logic [15:0] i_req_data = 16'h0000;
    logic        i_tx_busy = 1'b0;
    logic        i_err_clear = 1'b0;

    logic [1:0]  o_req_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [0:0]  o_grant_id;
    logic        o_active;
    logic        o_err_timeout;
    logic [15:0] o_byte_count;

    logic [1:0]  w_req_ready;
    logic [7:0]  w_tx_data;
    logic        w_tx_start;
    logic [0:0]  w_grant_id;
    logic        w_active;
    logic        w_err_timeout;
    logic [15:0] w_byte_count;

    int vectors = 0;
    int miscompares = 0;

    int busy_len = 0;
    int busy_cnt = 0;
    logic busy_force = 1'b0;

    typedef struct packed {
        logic [7:0] grant;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    uart_tx_scheduler #(.N_REQ(2), .BUSY_TIMEOUT(8)) dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_req_valid(i_req_valid),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id),
        .o_active(o_active), .o_err_timeout(o_err_timeout), .i_err_clear(i_err_clear),
        .o_byte_count(o_byte_count)
    );

    uart_tx_scheduler #(.N_REQ(2), .BUSY_TIMEOUT(8), .BYTE_COUNT_INIT(16'hFFFF)) dut_wrap (
        .clk(clk), .i_reset_n(i_reset_n), .i_req_valid(i_req_valid),
        .i_req_data(i_req_data), .o_req_ready(w_req_ready), .o_tx_data(w_tx_data),
        .o_tx_start(w_tx_start), .i_tx_busy(i_tx_busy), .o_grant_id(w_grant_id),
        .o_active(w_active), .o_err_timeout(w_err_timeout), .i_err_clear(i_err_clear),
        .o_byte_count(w_byte_count)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after start, for busy_len cycles.
    always @(negedge clk) begin
        if (!i_reset_n) begin
            busy_cnt  = 0;
            i_tx_busy = busy_force;
        end else begin
            i_tx_busy = busy_force | (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt--;
            if (o_tx_start && busy_len != 0) busy_cnt = busy_len;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] g, input logic [7:0] d);
        exp_t e;
        e.grant = g;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic check_start();
        exp_t e;
        e.grant = 'x;
        e.data  = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        chk("tx_data", o_tx_data, e.data);
        chk("grant_id", o_grant_id, e.grant);
        chk("wrap_tx_data", w_tx_data, e.data);
    endtask

    task automatic serve(input int budget);
        int n = 0;
        while (!o_tx_start && n < budget) begin
            cyc();
            n++;
        end
        chk("start_seen", o_tx_start, 1);
        check_start();
        cyc();
        chk("start_one_cycle", o_tx_start, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_active && n < budget) begin
            cyc();
            n++;
        end
        chk("return_idle", o_active, 0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        #1;
    endtask

    initial begin
        int acc;
        int last;

        // Reset state
        #1 i_reset_n = 1'b0;
        #2;
        chk("rst_ready", o_req_ready, 0);
        chk("rst_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_grant", o_grant_id, 0);
        chk("rst_active", o_active, 0);
        chk("rst_err", o_err_timeout, 0);
        chk("rst_count", o_byte_count, 0);
        chk("rst_wrap_count", w_byte_count, 16'hFFFF);
        chk("rst_wrap_misc", {w_req_ready, w_tx_start, w_grant_id, w_active, w_err_timeout}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 i_reset_n = 1'b1;
        cyc();

        // 1: single byte on req0
        busy_len = 10;
        i_req_data[7:0] = 8'h41;
        i_req_valid = 2'b01;
        #1;
        chk("t1_ready", o_req_ready, 2'b01);
        push_exp(8'd0, 8'h41);
        cyc();
        i_req_valid = 2'b00;
        chk("t1_ready_drop", o_req_ready, 0);
        chk("t1_start", o_tx_start, 1);
        serve(0);
        wait_idle(40);
        chk("t1_count", o_byte_count, 1);
        chk("t6_wrap", w_byte_count, 16'h0000);
        chk("t1_hold_data", o_tx_data, 8'h41);

        // 2: both requesters continuously valid
        do_reset();
        i_req_data = {8'h22, 8'h11};
        push_exp(8'd0, 8'h11);
        push_exp(8'd1, 8'h22);
        push_exp(8'd0, 8'h11);
        push_exp(8'd1, 8'h22);
        i_req_valid = 2'b11;
        #1;
        acc = 0;
        last = 0;
        for (int c = 0; c < 200 && acc < 4; c++) begin
            if (o_tx_start) check_start();
            if (o_req_ready != 0) begin
                chk("t2_rr_ready", o_req_ready, 32'(1) << sb[0].grant);
                if (acc > 0) chk("t2_gap", c - last, 13);
                last = c;
                acc++;
            end
            cyc();
        end
        chk("t2_accepts", acc, 4);
        i_req_valid = 2'b00;
        serve(0);
        wait_idle(40);
        chk("t2_count", o_byte_count, 4);

        // 3: transmitter never responds -> timeout, then clear and recover
        busy_len = 0;
        i_req_data[15:8] = 8'h5A;
        i_req_valid = 2'b10;
        #1;
        chk("t3_ready", o_req_ready, 2'b10);
        push_exp(8'd1, 8'h5A);
        cyc();
        i_req_valid = 2'b00;
        serve(0);
        repeat (7) cyc();
        chk("t3_err_early", o_err_timeout, 0);
        chk("t3_active_early", o_active, 1);
        cyc();
        chk("t3_err_set", o_err_timeout, 1);
        chk("t3_active_drop", o_active, 0);
        chk("t3_count_same", o_byte_count, 4);
        i_err_clear = 1'b1;
        cyc();
        i_err_clear = 1'b0;
        chk("t3_err_clear", o_err_timeout, 0);
        busy_len = 3;
        i_req_data[7:0] = 8'h77;
        i_req_valid = 2'b01;
        #1;
        chk("t3_next_ready", o_req_ready, 2'b01);
        push_exp(8'd0, 8'h77);
        cyc();
        i_req_valid = 2'b00;
        serve(0);
        wait_idle(40);
        chk("t3_next_count", o_byte_count, 5);

        // 3b: clear held during timeout event, set wins
        busy_len = 0;
        i_req_data[15:8] = 8'h5B;
        i_req_valid = 2'b10;
        i_err_clear = 1'b1;
        #1;
        push_exp(8'd1, 8'h5B);
        cyc();
        i_req_valid = 2'b00;
        serve(0);
        repeat (8) cyc();
        chk("t3b_set_wins", o_err_timeout, 1);
        cyc();
        chk("t3b_clear_after", o_err_timeout, 0);
        i_err_clear = 1'b0;

        // 4: busy held high in idle blocks acceptance
        busy_len = 4;
        busy_force = 1'b1;
        @(negedge clk);
        #1;
        i_req_data[15:8] = 8'h99;
        i_req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4_blocked", o_req_ready, 0);
        end
        busy_force = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_ready_on_fall", o_req_ready, 2'b10);
        push_exp(8'd1, 8'h99);
        cyc();
        i_req_valid = 2'b00;
        serve(0);
        wait_idle(40);
        chk("t4_count", o_byte_count, 6);

        // 5: reset during WAIT_DONE
        busy_len = 20;
        i_req_data[7:0] = 8'h33;
        i_req_valid = 2'b01;
        #1;
        push_exp(8'd0, 8'h33);
        cyc();
        i_req_valid = 2'b00;
        serve(0);
        repeat (3) cyc();
        chk("t5_in_flight", o_active, 1);
        i_req_data = {8'h22, 8'h11};
        i_req_valid = 2'b11;
        i_reset_n = 1'b0;
        #1;
        chk("t5_rst_active", o_active, 0);
        chk("t5_rst_ready", o_req_ready, 0);
        chk("t5_rst_data", o_tx_data, 0);
        chk("t5_rst_count", o_byte_count, 0);
        chk("t5_rst_start", o_tx_start, 0);
        @(negedge clk);
        @(posedge clk);
        #1 i_reset_n = 1'b1;
        #1;
        chk("t5_ptr_zero", o_req_ready, 2'b01);
        busy_len = 2;
        push_exp(8'd0, 8'h11);
        cyc();
        i_req_valid = 2'b00;
        serve(0);
        wait_idle(40);
        chk("t5_count", o_byte_count, 1);
        chk("t6_wrap_again", w_byte_count, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
